// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and memory-map constants.
// Used by the initiator and by the memory slave glue.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // HADDR[31:24] region tags decoded by the slave glue
  localparam logic [7:0] ROM_BASE = 8'hA0;
  localparam logic [7:0] RAM_BASE = 8'hB0;

endpackage

// File: rtl/ahb_master_if_if.sv
// Core request/response channel plus AHB-Lite bus, bundled for the initiator.
// The master modport is the initiator's view; slave is the core + memory side.
interface ahb_master_if_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // core side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [3:0]        req_prot;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // AHB-Lite side
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  htrans_t           htrans;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_prot, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output haddr, hwrite, hsize, hprot, htrans, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_prot, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  haddr, hwrite, hsize, hprot, htrans, hburst, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_master_if.sv
// AHB-Lite initiator: turns one-at-a-time core requests into pipelined single-beat
// transfers (address phase A overlapping data phase D) with in-order responses.
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  ahb_master_if_if.master bus
);

  typedef struct packed {
    logic              valid;
    logic              kill;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [3:0]        prot;
    logic [DATA_W-1:0] wdata;
  } a_reg_t;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } d_reg_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_reg_t;

  a_reg_t   a_q, a_d;
  d_reg_t   d_q, d_d;
  rsp_reg_t rsp_q, rsp_d;
  logic     kill_pend_q, kill_pend_d;

  logic req_ready;
  logic a_live;
  logic accept;

  // A killed transfer blocks new requests until its error response has gone out.
  assign req_ready = reset && bus.hready && !a_q.kill && !kill_pend_q;
  assign a_live    = a_q.valid && !a_q.kill;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    a_d         = a_q;
    d_d         = d_q;
    rsp_d       = '0;
    kill_pend_d = kill_pend_q;

    // D is always empty while a kill response is pending, so the two never collide.
    if (kill_pend_q) begin
      rsp_d.valid = 1'b1;
      rsp_d.err   = 1'b1;
      kill_pend_d = 1'b0;
    end

    if (bus.hready) begin
      if (d_q.valid) begin
        rsp_d.valid = 1'b1;
        rsp_d.err   = bus.hresp;
        rsp_d.rdata = (!d_q.write && !bus.hresp) ? bus.hrdata : '0;
      end

      d_d.valid = a_live;
      if (a_live) begin
        d_d.write = a_q.write;
        d_d.wdata = a_q.wdata;
      end

      if (a_q.valid && a_q.kill) begin
        kill_pend_d = 1'b1;
      end

      if (accept) begin
        a_d.valid = 1'b1;
        a_d.kill  = 1'b0;
        a_d.addr  = bus.req_addr;
        a_d.write = bus.req_write;
        a_d.size  = bus.req_size;
        a_d.prot  = bus.req_prot;
        a_d.wdata = bus.req_wdata;
      end else begin
        a_d.valid = 1'b0;
        a_d.kill  = 1'b0;
      end
    end else if (d_q.valid && bus.hresp && a_q.valid) begin
      // ERROR cycle 1: the pending address phase must go IDLE from the next cycle.
      a_d.kill = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      d_q         <= '0;
      rsp_q       <= '0;
      kill_pend_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      a_q         <= a_d;
      d_q         <= d_d;
      rsp_q       <= rsp_d;
      kill_pend_q <= kill_pend_d;
    end
  end

  always_comb begin
    bus.req_ready = req_ready;
    bus.haddr     = a_q.addr;
    bus.hwrite    = a_q.write;
    bus.hsize     = a_q.size;
    bus.hprot     = a_q.prot;
    bus.htrans    = a_live ? NONSEQ : IDLE;
    bus.hburst    = HBURST_SINGLE;
    bus.hwdata    = d_q.wdata;
    bus.rsp_valid = rsp_q.valid;
    bus.rsp_rdata = rsp_q.rdata;
    bus.rsp_err   = rsp_q.err;
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: expected responses are queued when requests are
// driven and compared (data, error flag, arrival cycle) when rsp_valid strobes.
module tb_ahb_master_if;
  import ahb_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ahb_master_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = '0;
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_size  = HSIZE_WORD;
    bus.req_prot  = 4'h3;
    bus.req_wdata = wdata;
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err, input int at_cyc);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.cyc   = at_cyc;
    sb.push_back(e);
  endtask

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      check("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int c;
    idle_inputs();
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_prot  = '0;
    bus.req_wdata = '0;

    // reset values
    tick();
    tick();
    check("rst_htrans", bus.htrans, IDLE);
    check("rst_haddr", bus.haddr, 32'h0);
    check("rst_hwrite", 32'(bus.hwrite), 32'd0);
    check("rst_hsize", 32'(bus.hsize), 32'd0);
    check("rst_hprot", 32'(bus.hprot), 32'd0);
    check("rst_hwdata", bus.hwdata, 32'h0);
    check("rst_hburst", 32'(bus.hburst), 32'(HBURST_SINGLE));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    tick();

    // single zero-wait read from ROM
    c = cyc;
    drive_req(1'b0, {ROM_BASE, 24'h000010}, 32'h0);
    push_exp(32'h1234_5678, 1'b0, c + 3);
    #1;
    check("rd_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("rd_htrans", bus.htrans, NONSEQ);
    check("rd_haddr", bus.haddr, 32'hA000_0010);
    check("rd_hwrite", 32'(bus.hwrite), 32'd0);
    check("rd_hsize", 32'(bus.hsize), 32'(HSIZE_WORD));
    check("rd_hprot", 32'(bus.hprot), 32'h3);
    tick();
    bus.hrdata = 32'h1234_5678;
    #1;
    check("rd_dphase_htrans", bus.htrans, IDLE);
    tick();
    bus.hrdata = '0;
    tick();
    tick();

    // back-to-back write then read to RAM
    c = cyc;
    drive_req(1'b1, {RAM_BASE, 24'h000004}, 32'hDEAD_BEEF);
    push_exp(32'h0, 1'b0, c + 3);
    tick();
    drive_req(1'b0, {RAM_BASE, 24'h000004}, 32'h0);
    push_exp(32'hDEAD_BEEF, 1'b0, c + 4);
    #1;
    check("b2b_req_ready", 32'(bus.req_ready), 32'd1);
    check("b2b_wr_hwrite", 32'(bus.hwrite), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.hrdata    = 32'h5555_5555;
    #1;
    check("b2b_rd_haddr", bus.haddr, 32'hB000_0004);
    check("b2b_rd_hwrite", 32'(bus.hwrite), 32'd0);
    check("b2b_rd_htrans", bus.htrans, NONSEQ);
    check("b2b_hwdata", bus.hwdata, 32'hDEAD_BEEF);
    tick();
    bus.hrdata = 32'hDEAD_BEEF;
    tick();
    bus.hrdata = '0;
    tick();
    tick();

    // read with two wait states, second read held in its address phase
    c = cyc;
    drive_req(1'b0, {ROM_BASE, 24'h000020}, 32'h1111_2222);
    push_exp(32'hCAFE_F00D, 1'b0, c + 5);
    tick();
    drive_req(1'b0, {RAM_BASE, 24'h000010}, 32'h3333_4444);
    push_exp(32'h0BAD_C0DE, 1'b0, c + 6);
    #1;
    check("ws_req_ready_pre", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.hready    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ws_req_ready", 32'(bus.req_ready), 32'd0);
      check("ws_haddr", bus.haddr, 32'hB000_0010);
      check("ws_htrans", bus.htrans, NONSEQ);
      check("ws_hwdata", bus.hwdata, 32'h1111_2222);
      tick();
    end
    bus.hready = 1'b1;
    bus.hrdata = 32'hCAFE_F00D;
    #1;
    check("ws_release_ready", 32'(bus.req_ready), 32'd1);
    check("ws_release_haddr", bus.haddr, 32'hB000_0010);
    check("ws_release_htrans", bus.htrans, NONSEQ);
    tick();
    bus.hrdata = 32'h0BAD_C0DE;
    #1;
    check("ws_d2_hwdata", bus.hwdata, 32'h3333_4444);
    tick();
    bus.hrdata = '0;
    tick();
    tick();

    // ERROR on a ROM write while a RAM read waits in its address phase
    c = cyc;
    drive_req(1'b1, {ROM_BASE, 24'h000000}, 32'h0000_0077);
    push_exp(32'h0, 1'b1, c + 4);
    tick();
    drive_req(1'b0, {RAM_BASE, 24'h000008}, 32'h0);
    push_exp(32'h0, 1'b1, c + 5);
    tick();
    bus.req_valid = 1'b0;
    bus.hresp     = 1'b1;
    bus.hready    = 1'b0;
    #1;
    check("err1_htrans", bus.htrans, NONSEQ);
    check("err1_req_ready", 32'(bus.req_ready), 32'd0);
    check("err1_hwdata", bus.hwdata, 32'h0000_0077);
    tick();
    bus.hready = 1'b1;
    bus.hrdata = 32'hFFFF_FFFF;
    #1;
    check("err2_htrans", bus.htrans, IDLE);
    check("err2_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.hresp  = 1'b0;
    bus.hrdata = '0;
    #1;
    check("err_pend_htrans", bus.htrans, IDLE);
    check("err_pend_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    #1;
    check("err_done_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    tick();

    // reset asserted in the middle of a data phase
    drive_req(1'b0, {ROM_BASE, 24'h000040}, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.hrdata = 32'h9999_9999;
    #2;
    reset = 1'b0;
    #1;
    check("arst_htrans", bus.htrans, IDLE);
    check("arst_haddr", bus.haddr, 32'h0);
    check("arst_hwdata", bus.hwdata, 32'h0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    reset = 1'b1;
    bus.hrdata = '0;
    tick();
    tick();
    tick();

    // fresh single read after reset release
    c = cyc;
    drive_req(1'b0, {ROM_BASE, 24'h000010}, 32'h0);
    push_exp(32'h600D_0001, 1'b0, c + 3);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("post_rst_htrans", bus.htrans, NONSEQ);
    check("post_rst_haddr", bus.haddr, 32'hA000_0010);
    tick();
    bus.hrdata = 32'h600D_0001;
    tick();
    bus.hrdata = '0;
    tick();
    tick();

    // idle for 10 cycles with stray hresp pulses
    for (int i = 0; i < 10; i++) begin
      bus.hresp = i[0];
      #1;
      check("idle_htrans", bus.htrans, IDLE);
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.hresp = 1'b0;
    tick();
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
